div: RTL and testbench



---
 rtl/div_if.sv | 22 ++
 rtl/div.sv | 143 ++++++++++++++
 tb/tb_div.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// Operand/result bundle between the execute stage and the divider.
interface div_if #(
  parameter int WIDTH = 32
);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div.sv
// Radix-2 restoring divider: one quotient bit per cycle, signed/unsigned.
//
// state  | meaning
// FREE   | idle, waiting for start_i
// BYZERO | divisor was zero, report a zero result next edge
// ON     | iterating, one quotient bit per edge
// END    | result valid, held while start_i stays high
module div #(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic               sgn_q, sgn_d;
  logic               neg1_q, neg1_d;
  logic               neg2_q, neg2_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic               op1_neg, op2_neg;
  logic [WIDTH-1:0]   op1_abs, op2_abs;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   quo_fin, rem_fin;

  // Operand magnitudes and the trial subtract of the current iteration.
  // The subtract takes the remainder plus the next dividend bit (WIDTH+1
  // bits) so the shifted-out remainder MSB is never lost.
  always_comb begin
    op1_neg = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
    op2_neg = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
    op1_abs = op1_neg ? (~bus.opdata1_i + WIDTH'(1)) : bus.opdata1_i;
    op2_abs = op2_neg ? (~bus.opdata2_i + WIDTH'(1)) : bus.opdata2_i;
    trial   = work_q[2*WIDTH-1:WIDTH-1] - {1'b0, dvsr_q};
    quo_fin = (sgn_q & (neg1_q ^ neg2_q)) ? (~work_q[WIDTH-1:0] + WIDTH'(1))
                                          : work_q[WIDTH-1:0];
    rem_fin = (sgn_q & neg1_q) ? (~work_q[2*WIDTH-1:WIDTH] + WIDTH'(1))
                               : work_q[2*WIDTH-1:WIDTH];
  end

  // Next-state, datapath update and output values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    dvsr_d   = dvsr_q;
    sgn_d    = sgn_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    result_d = result_q;
    ready_d  = ready_q;
    unique case (state_q)
      FREE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (bus.start_i && !bus.annul_i) begin
          if (bus.opdata2_i == '0) begin
            state_d = BYZERO;
          end else begin
            state_d = ON;
            sgn_d   = bus.signed_div_i;
            neg1_d  = op1_neg;
            neg2_d  = op2_neg;
            work_d  = {{WIDTH{1'b0}}, op1_abs};
            dvsr_d  = op2_abs;
            cnt_d   = '0;
          end
        end
      end
      BYZERO: begin
        if (bus.annul_i) begin
          state_d = FREE;
        end else begin
          state_d  = END;
          result_d = '0;
          ready_d  = 1'b1;
        end
      end
      ON: begin
        if (bus.annul_i) begin
          state_d  = FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end else if (cnt_q != CW'(WIDTH)) begin
          if (!trial[WIDTH]) begin
            work_d = {trial[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
          end else begin
            work_d = {work_q[2*WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CW'(1);
        end else begin
          state_d  = END;
          result_d = {rem_fin, quo_fin};
          ready_d  = 1'b1;
        end
      end
      END: begin
        if (!bus.start_i) begin
          state_d  = FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: state_d = FREE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FREE;
      cnt_q    <= '0;
      work_q   <= '0;
      dvsr_q   <= '0;
      sgn_q    <= 1'b0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      dvsr_q   <= dvsr_d;
      sgn_q    <= sgn_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
endmodule

// File: tb/tb_div.sv
module tb_div;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  div_if #(.WIDTH(32)) bus ();

  div #(.WIDTH(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic, truncating toward zero, remainder takes
  // the sign of the dividend; zero divisor yields zero; the single signed
  // overflow case wraps.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (!s) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sa = $signed(a);
    sb = $signed(b);
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Issue one division with start held, measure edges until ready, check
  // the result, its hold (with annul asserted, which must be ignored) and
  // the clear once start drops.
  task automatic run_div(input string name, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
    int n;
    int exp_edges;
    exp_edges = (b == 32'd0) ? 2 : 34;
    @(negedge clk);
    bus.signed_div_i = s;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.ready_o && n < 40);
    chk({name, "_latency"}, 64'(n), 64'(exp_edges));
    chk({name, "_result"}, bus.result_o, exp);
    @(negedge clk);
    bus.annul_i   = 1'b1;
    bus.opdata1_i = $urandom;
    bus.opdata2_i = $urandom;
    @(posedge clk);
    #1;
    chk({name, "_hold"}, {bus.ready_o, bus.result_o}, {1'b1, exp});
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    @(posedge clk);
    #1;
    chk({name, "_clear"}, {bus.ready_o, bus.result_o}, 65'd0);
  endtask

  vec_t vecs[$];

  initial begin
    int seen_ready;
    vecs.push_back('{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E});
    vecs.push_back('{1'b1, 32'hFFFF_FFF9,  32'd2,          64'hFFFFFFFF_FFFFFFFD});
    vecs.push_back('{1'b1, 32'd7,          32'hFFFF_FFFE,  64'h00000001_FFFFFFFD});
    vecs.push_back('{1'b1, 32'h1234_5678,  32'd0,          64'h0});
    vecs.push_back('{1'b0, 32'hFFFF_FFFF,  32'd1,          64'h00000000_FFFFFFFF});
    vecs.push_back('{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  64'h00000000_80000000});
    vecs.push_back('{1'b0, 32'd5,          32'd9,          64'h00000005_00000000});
    vecs.push_back('{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h00000000_00000001});
    vecs.push_back('{1'b0, 32'hFFFF_FFFF,  32'h8000_0001,  64'h7FFFFFFE_00000001});
    vecs.push_back('{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  64'hFFFFFFFF_00000003});

    rst              = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {bus.ready_o, bus.result_o}, 65'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_free", {bus.ready_o, bus.result_o}, 65'd0);

    foreach (vecs[i]) run_div($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Annul mid-operation, then restart on the very next edge.
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    seen_ready = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus.ready_o) seen_ready = 1;
    end
    @(negedge clk);
    bus.annul_i = 1'b1;
    @(posedge clk);
    #1;
    if (bus.ready_o) seen_ready = 1;
    chk("annul_no_ready", 64'(seen_ready), 64'd0);
    chk("annul_clear", {bus.ready_o, bus.result_o}, 65'd0);
    run_div("after_annul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003);

    // Synchronous reset in the middle of an operation.
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_on", {bus.ready_o, bus.result_o}, 65'd0);
    @(negedge clk);
    rst         = 1'b0;
    bus.start_i = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("rst_stays_free", {bus.ready_o, bus.result_o}, 65'd0);
    run_div("after_rst", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003);

    // Random operands against the arithmetic reference.
    for (int k = 0; k < 150; k++) begin
      logic        s;
      logic [31:0] a, b;
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        3: b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      run_div($sformatf("rnd%0d", k), s, a, b, ref_div(s, a, b));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
